// File: rtl/paralelo_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : paralelo_serial_tx_if
// Description : Byte-side valid/ready handshake between a byte source and the
//               paralelo_serial_tx lane serializer.
//   data_in   [7:0]  byte offered by the source
//   valid_in         data_in is valid this cycle
//   ready_out        serializer buffer can accept a byte this cycle
//   Modports: master = byte source, slave = serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface paralelo_serial_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out
    );
endinterface : paralelo_serial_tx_if
`default_nettype wire

// File: rtl/paralelo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : paralelo_serial_tx
// Description : Transmit-lane serializer for one phy_rx serial input. Bytes
//               are buffered in a small circular FIFO and shifted out
//               MSB-first, one bit per clk_32f. When no byte is available at
//               a byte boundary the COMMA idle byte is sent instead, giving
//               the receiver alignment and activity detection.
//   clk_32f          in   bit clock, only clock of the block
//   reset            in   synchronous, active-high
//   bus (slave)      byte handshake: data_in[7:0], valid_in in; ready_out out
//   data_out         out  serial bit
//   byte_start       out  pulse: data_out carries bit 7 of a new byte
//   data_valid       out  data_out belongs to a data byte (0 = COMMA)
// Build option: TX_STARTUP_COMMA_EN - when defined, at least STARTUP_COMMAS
//               COMMA bytes are sent after reset before any data is popped.
// Revision    : 1.0 - initial release
// ============================================================================
module paralelo_serial_tx #(
    parameter logic [7:0]  COMMA          = 8'hBC,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned STARTUP_COMMAS = 4
) (
    input  wire logic                 clk_32f,
    input  wire logic                 reset,
    paralelo_serial_tx_if.slave       bus,
    output logic                      data_out,
    output logic                      byte_start,
    output logic                      data_valid
);

    localparam int unsigned c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    generate
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("paralelo_serial_tx: FIFO_DEPTH must be a power of 2 and >= 2");
        end
        if (STARTUP_COMMAS < 1) begin : g_bad_startup
            $error("paralelo_serial_tx: STARTUP_COMMAS must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shreg;
    logic               r_load_flag;    // byte now in r_shreg was popped data
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [7:0]         r_mem [FIFO_DEPTH];

    logic               w_boundary;
    logic               w_push;
    logic               w_pop;
    logic               w_gate_open;
    logic [c_cnt_w-1:0] w_count_nxt;

    // Bit 7 of the current byte is driven when r_bit_cnt==0, so the next
    // byte must already be in r_shreg when the counter wraps from 7.
    assign w_boundary = (r_bit_cnt == 3'd7);

    // ready_out is registered from the count, so it is a safe acceptance
    // qualifier for this cycle.
    assign w_push = bus.valid_in && bus.ready_out;

    // Pop only at a boundary; a byte pushed on this same edge is not yet
    // counted in r_count, so there is deliberately no bypass path.
    assign w_pop = w_boundary && (r_count != '0) && w_gate_open;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Startup gate
    // ------------------------------------------------------------------
`ifdef TX_STARTUP_COMMA_EN
    localparam int unsigned c_sc_w = $clog2(STARTUP_COMMAS + 1);
    logic [c_sc_w-1:0] r_startup_cnt;

    // r_startup_cnt counts COMMA bytes loaded at boundaries. The COMMA
    // placed in r_shreg by reset is the first idle byte on the wire, so the
    // gate opens at the boundary where STARTUP_COMMAS idle bytes have been
    // completed, i.e. once STARTUP_COMMAS-1 have been loaded.
    assign w_gate_open = (r_startup_cnt >= c_sc_w'(STARTUP_COMMAS - 1));

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_startup_cnt <= '0;
        end else if (w_boundary && (r_startup_cnt != c_sc_w'(STARTUP_COMMAS))) begin
            r_startup_cnt <= r_startup_cnt + 1'b1;
        end
    end
`else
    assign w_gate_open = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Byte buffer storage (contents need no reset; count/pointers do)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_32f) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // ------------------------------------------------------------------
    // Buffer control, shifter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_bit_cnt     <= 3'd0;
            r_shreg       <= COMMA;
            r_load_flag   <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            bus.ready_out <= 1'b1;
            data_out      <= 1'b0;
            byte_start    <= 1'b0;
            data_valid    <= 1'b0;
        end else begin
            data_out   <= r_shreg[7];
            byte_start <= (r_bit_cnt == 3'd0);
            data_valid <= r_load_flag;
            r_bit_cnt  <= r_bit_cnt + 3'd1;

            if (w_boundary) begin
                r_shreg     <= w_pop ? r_mem[r_rd_ptr] : COMMA;
                r_load_flag <= w_pop;
            end else begin
                r_shreg <= {r_shreg[6:0], 1'b0};
            end

            // Power-of-2 depth: pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            r_count       <= w_count_nxt;
            bus.ready_out <= (w_count_nxt != c_depth);
        end
    end

endmodule : paralelo_serial_tx
`default_nettype wire

// File: tb/tb_paralelo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_paralelo_serial_tx
// Description : Self-checking bench for paralelo_serial_tx. A byte-slot
//               reference model (queue of buffered bytes, one 8-cycle slot per
//               byte, slot choice made at every 8th edge) predicts every output
//               bit, byte_start, data_valid and ready_out. A small deserializer
//               recovers data bytes from the DUT stream for an order check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paralelo_serial_tx;

    localparam logic [7:0]  COMMA          = 8'hBC;
    localparam int unsigned FIFO_DEPTH     = 2;
    localparam int unsigned STARTUP_COMMAS = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    logic data_out;
    logic byte_start;
    logic data_valid;

    paralelo_serial_tx_if bus ();

    paralelo_serial_tx #(
        .COMMA          (COMMA),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .STARTUP_COMMAS (STARTUP_COMMAS)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .bus        (bus),
        .data_out   (data_out),
        .byte_start (byte_start),
        .data_valid (data_valid)
    );

    always #5 clk_32f = ~clk_32f;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int         n;              // edges since reset release
    logic [7:0] mq[$];          // bytes held in the buffer
    logic [7:0] cur, nxt;       // byte in current slot / chosen for next slot
    bit         cur_data, nxt_data;
    logic [7:0] exp_rx[$];      // data bytes fully sent, in order
    logic [7:0] src_q[$];       // source-side bytes waiting to be offered

    // Deserializer of DUT output
    logic [7:0] rx_sh;
    int         rx_bits;
    logic [7:0] rx_q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    function automatic bit gate_open(input int k);
`ifdef TX_STARTUP_COMMA_EN
        return (k >= int'(STARTUP_COMMAS));
`else
        return (k >= 0);
`endif
    endfunction

    task automatic model_init();
        n        = 0;
        mq.delete();
        cur      = COMMA;
        cur_data = 1'b0;
        nxt      = COMMA;
        nxt_data = 1'b0;
        rx_bits  = 0;
        rx_sh    = '0;
    endtask

    // Called just after a negedge; holds reset for 'cycles' edges.
    task automatic do_reset(input int cycles);
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        repeat (cycles) begin
            @(posedge clk_32f);
            @(negedge clk_32f);
            chk("rst_data_out",   {7'd0, data_out},      8'd0);
            chk("rst_byte_start", {7'd0, byte_start},    8'd0);
            chk("rst_data_valid", {7'd0, data_valid},    8'd0);
            chk("rst_ready_out",  {7'd0, bus.ready_out}, 8'd1);
        end
        reset = 1'b0;
        model_init();
    endtask

    // One clock: drive inputs, predict, advance, check.
    task automatic tick(input logic v, input logic [7:0] d, output bit acc);
        bit exp_ready;
        int idx;
        bus.valid_in = v;
        bus.data_in  = d;
        exp_ready = (mq.size() != int'(FIFO_DEPTH));
        chk("ready_out", {7'd0, bus.ready_out}, {7'd0, exp_ready});
        acc = v && exp_ready;

        @(posedge clk_32f);
        n++;
        // Slot selection happens on every 8th edge from the buffer as it
        // stood before this edge's push.
        if ((n % 8) == 0) begin
            if (gate_open(n / 8) && (mq.size() > 0)) begin
                nxt      = mq.pop_front();
                nxt_data = 1'b1;
            end else begin
                nxt      = COMMA;
                nxt_data = 1'b0;
            end
        end
        if (acc) mq.push_back(d);
        if ((n > 1) && ((n - 1) % 8) == 0) begin
            cur      = nxt;
            cur_data = nxt_data;
        end
        idx = 7 - ((n - 1) % 8);

        @(negedge clk_32f);
        chk("data_out",   {7'd0, data_out},   {7'd0, cur[idx]});
        chk("byte_start", {7'd0, byte_start}, {7'd0, (idx == 7)});
        chk("data_valid", {7'd0, data_valid}, {7'd0, cur_data});
        if ((idx == 0) && cur_data) exp_rx.push_back(cur);

        rx_sh = {rx_sh[6:0], data_out};
        if (byte_start) rx_bits = 1;
        else if (rx_bits > 0) rx_bits++;
        if (rx_bits == 8) begin
            if (data_valid) rx_q.push_back(rx_sh);
            rx_bits = 0;
        end
    endtask

    // Source holds its head byte until accepted; rate_pct adds random bytes.
    task automatic run_src(input int cycles, input int rate_pct);
        bit         acc;
        logic [7:0] b;
        for (int c = 0; c < cycles; c++) begin
            if ((rate_pct > 0) && (src_q.size() < 4) && ($urandom_range(99) < rate_pct)) begin
                b = ($urandom_range(9) == 0) ? COMMA : 8'($urandom);
                src_q.push_back(b);
            end
            if (src_q.size() > 0) tick(1'b1, src_q[0], acc);
            else                  tick(1'b0, 8'($urandom), acc);
            if (acc) void'(src_q.pop_front());
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        model_init();
        @(negedge clk_32f);

        // T1: idle stream of COMMAs
        do_reset(3);
        run_src(64, 0);

        // T2: single byte pushed at cycle 2
        do_reset(2);
        run_src(1, 0);
        src_q.push_back(8'hA5);
        run_src(31, 0);

        // T3: back-to-back pushes with backpressure
        do_reset(2);
        src_q = '{8'h11, 8'h22, 8'h33};
        run_src(48, 0);

        // T4: push on a boundary cycle into an empty buffer
        do_reset(2);
        run_src(7, 0);
        src_q.push_back(8'h3C);
        run_src(25, 0);

        // T5: reset at bit 3 of F0 with one byte still queued
        do_reset(2);
        src_q = '{8'hF0, 8'h77};
        run_src(12, 0);
        do_reset(3);
        run_src(32, 0);

        // T6: startup gate (prediction covers both builds)
        do_reset(2);
        src_q.push_back(8'h55);
        run_src(56, 0);

        // Randomized traffic, light then heavy load, across a mid-run reset
        do_reset(2);
        run_src(400, 40);
        run_src(13, 90);
        src_q.delete();
        do_reset(2);
        run_src(400, 90);
        src_q.delete();
        run_src(24, 0);

        // Recovered data bytes match the model in order
        chk("rx_count", 8'(rx_q.size()), 8'(exp_rx.size()));
        for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++) begin
            chk("rx_byte", rx_q[i], exp_rx[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_paralelo_serial_tx
`default_nettype wire
